// File: rtl/alu_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// opcodes: shared types and constants for the alu_dispatch block.
//   instruction_t    - 32-bit RV32I instruction word
//   register_t       - 32-bit architectural register value
//   OPC_*            - major opcodes the dispatcher can issue
//   dispatch_state_t - dispatcher FSM state encoding
//   is_supported()   - true for the opcodes above
// ---------------------------------------------------------------------------
package opcodes;

    typedef logic [31:0] instruction_t;
    typedef logic [31:0] register_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } dispatch_state_t;

    function automatic logic is_supported(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
               (opc == OPC_LUI) || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// ---------------------------------------------------------------------------
// alu_dispatch_if: fetch handshake, ALU issue/return and retire pulses.
//   slave  - the dispatcher's view (drives in_ready, alu_*, done, illegal)
//   master - the environment's view (fetch + ALU side)
// ---------------------------------------------------------------------------
interface alu_dispatch_if;
    import opcodes::*;

    logic         in_valid;
    logic         in_ready;
    instruction_t in_instr;
    register_t    in_pc;

    instruction_t alu_instr;
    register_t    alu_op1;
    register_t    alu_op2;
    logic         alu_enable;
    logic         alu_instr_exec;
    register_t    alu_result;

    logic         done;
    logic         illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, alu_instr_exec, alu_result,
        output in_ready, alu_instr, alu_op1, alu_op2, alu_enable, done, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, alu_instr_exec, alu_result,
        input  in_ready, alu_instr, alu_op1, alu_op2, alu_enable, done, illegal
    );

endinterface

// File: rtl/alu_dispatch_regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32 x 32-bit register file, x0 reads as zero.
//   clk, rst_n            - clock, synchronous active-low reset (clears all)
//   i_rs1_addr/o_rs1_data - combinational read port 1
//   i_rs2_addr/o_rs2_data - combinational read port 2
//   i_dbg_addr/o_dbg_data - combinational debug read port
//   i_we, i_wr_addr, i_wr_data - synchronous write port (x0 writes dropped)
// ---------------------------------------------------------------------------
module regfile
    import opcodes::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic [4:0] i_dbg_addr,
    output register_t  o_rs1_data,
    output register_t  o_rs2_data,
    output register_t  o_dbg_data,
    input  logic       i_we,
    input  logic [4:0] i_wr_addr,
    input  register_t  i_wr_data
);

    register_t r_regs [32];

    // NOTE: this array is cleared on reset only because the block must come
    // out of reset with every register at zero; storage without that
    // requirement should not be reset, so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != 5'd0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // x0 is forced to zero on read so its storage never matters.
    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch: single-issue RV32I dispatcher for OP / OP-IMM / LUI / AUIPC.
// Accepts one instruction in IDLE, presents it with operands to an external
// ALU for one ISSUE cycle, then in WAIT retires the registered ALU result to
// rd (done) or rejects it (illegal). Throughput is one instruction per three
// cycles.
//   trace    - nonzero: print each issued instruction (simulation only)
//   clk      - clock, all state on rising edge
//   rst_n    - synchronous active-low reset
//   bus      - fetch handshake, ALU interface and done/illegal pulses
//   dbg_addr - debug register-file read address
//   dbg_data - combinational debug read data
// ---------------------------------------------------------------------------
module alu_dispatch
    import opcodes::*;
#(
    parameter int trace = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_dispatch_if.slave bus,
    input  logic [4:0]    dbg_addr,
    output register_t     dbg_data
);

    dispatch_state_t r_state;
    instruction_t    r_instr;
    register_t       r_op1;
    register_t       r_op2;
    logic            r_done;
    logic            r_illegal;

    logic [6:0] w_opcode;
    logic       w_supported;
    register_t  w_rs1_data;
    register_t  w_rs2_data;
    register_t  w_op1;
    register_t  w_op2;
    register_t  w_imm_i;
    register_t  w_imm_u;
    logic       w_we;

    assign w_opcode    = bus.in_instr[6:0];
    assign w_supported = is_supported(w_opcode);
    assign w_imm_i     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign w_imm_u     = {bus.in_instr[31:12], 12'b0};

    // Retire only from WAIT with the ALU's acceptance; reset blocks the write.
    assign w_we = rst_n && (r_state == WAIT) && bus.alu_instr_exec;

    regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (bus.in_instr[19:15]),
        .i_rs2_addr (bus.in_instr[24:20]),
        .i_dbg_addr (dbg_addr),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data),
        .i_we       (w_we),
        .i_wr_addr  (r_instr[11:7]),
        .i_wr_data  (bus.alu_result)
    );

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_op1 = w_rs1_data;
        w_op2 = w_rs2_data;
        case (w_opcode)
            OPC_OP_IMM: w_op2 = w_imm_i;
            OPC_LUI: begin
                w_op1 = w_imm_u;
                w_op2 = '0;
            end
            OPC_AUIPC: begin
                w_op1 = w_imm_u;
                w_op2 = bus.in_pc;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_supported) begin
                            r_instr <= bus.in_instr;
                            r_op1   <= w_op1;
                            r_op2   <= w_op2;
                            r_state <= ISSUE;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    // done and illegal come from disjoint branches here and
                    // from IDLE, so they can never pulse together.
                    if (bus.alu_instr_exec) begin
                        r_done <= 1'b1;
                    end else begin
                        r_illegal <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.alu_enable = (r_state == ISSUE);
    assign bus.alu_instr  = r_instr;
    assign bus.alu_op1    = r_op1;
    assign bus.alu_op2    = r_op2;
    assign bus.done       = r_done;
    assign bus.illegal    = r_illegal;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if ((trace != 0) && rst_n && (r_state == IDLE) && bus.in_valid && w_supported) begin
            $display("alu_dispatch: issue pc=%08h instr=%08h op1=%08h op2=%08h",
                     bus.in_pc, bus.in_instr, w_op1, w_op2);
        end
    end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_dispatch: directed vectors with hand-computed expectations.
// Stimulus pushes expected ALU issues, retire/reject events and register
// probes into queues; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_alu_dispatch;
    import opcodes::*;

    typedef struct {
        instruction_t instr;
        register_t    op1;
        register_t    op2;
        int           cyc;
    } alu_exp_t;

    typedef struct {
        logic        is_done;
        int          cyc;
        logic [4:0]  chk_addr;
        register_t   chk_val;
    } resp_exp_t;

    typedef struct {
        logic [4:0] addr;
        register_t  val;
    } probe_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] dbg_addr = 5'd0;
    register_t  dbg_data;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       alu_reject = 1'b0;

    alu_exp_t  alu_q[$];
    resp_exp_t resp_q[$];
    probe_t    probe_q[$];

    alu_dispatch_if bus ();

    alu_dispatch #(.trace(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: registered add/sub, optionally refuses to execute.
    always @(posedge clk) begin
        bus.alu_instr_exec <= 1'b0;
        if (bus.alu_enable) begin
            bus.alu_instr_exec <= !alu_reject;
            if (bus.alu_instr[6:0] == OPC_OP && bus.alu_instr[30])
                bus.alu_result <= bus.alu_op1 - bus.alu_op2;
            else
                bus.alu_result <= bus.alu_op1 + bus.alu_op2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h expected=%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: ALU issues, retire/reject pulses and register probes.
    initial begin
        alu_exp_t  a;
        resp_exp_t r;
        probe_t    p;
        logic      prev_en = 1'b0;
        alu_exp_t  last;
        forever begin
            @(negedge clk);
            if (prev_en) begin
                check("hold_instr", bus.alu_instr, last.instr);
                check("hold_op1", bus.alu_op1, last.op1);
                check("hold_op2", bus.alu_op2, last.op2);
            end
            prev_en = 1'b0;
            if (bus.alu_enable === 1'b1) begin
                if (alu_q.size() == 0) begin
                    check("unexpected_alu_enable", {31'b0, bus.alu_enable}, 32'd0);
                end else begin
                    a = alu_q.pop_front();
                    check("alu_cycle", cyc, a.cyc);
                    check("alu_instr", bus.alu_instr, a.instr);
                    check("alu_op1", bus.alu_op1, a.op1);
                    check("alu_op2", bus.alu_op2, a.op2);
                    last = a;
                    prev_en = 1'b1;
                end
            end
            if (bus.done === 1'b1 || bus.illegal === 1'b1) begin
                check("done_and_illegal", {31'b0, bus.done & bus.illegal}, 32'd0);
                if (resp_q.size() == 0) begin
                    check("unexpected_done", {31'b0, bus.done}, 32'd0);
                    check("unexpected_illegal", {31'b0, bus.illegal}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_done", {31'b0, bus.done}, {31'b0, r.is_done});
                    check("resp_illegal", {31'b0, bus.illegal}, {31'b0, !r.is_done});
                    dbg_addr = r.chk_addr;
                    #1;
                    check($sformatf("resp_x%0d", r.chk_addr), dbg_data, r.chk_val);
                end
            end
            while (probe_q.size() != 0) begin
                p = probe_q.pop_front();
                dbg_addr = p.addr;
                #1;
                check($sformatf("probe_x%0d", p.addr), dbg_data, p.val);
            end
        end
    end

    // Offer one instruction on a falling edge once in_ready is seen; returns
    // the cycle number in which it was accepted.
    task automatic issue(input instruction_t instr, input register_t pc, output int acc);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        acc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_ok(input int acc, input instruction_t instr, input register_t op1,
                             input register_t op2, input logic [4:0] rd, input register_t val);
        alu_q.push_back('{instr: instr, op1: op1, op2: op2, cyc: acc + 1});
        resp_q.push_back('{is_done: 1'b1, cyc: acc + 3, chk_addr: rd, chk_val: val});
    endtask

    initial begin
        int acc;
        int acc_prev;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc    = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_alu_enable", {31'b0, bus.alu_enable}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_illegal", {31'b0, bus.illegal}, 32'd0);
        check("rst_op1", bus.alu_op1, 32'd0);
        check("rst_instr", bus.alu_instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

        // ADDI x1,x0,5
        issue(32'h00500093, 32'h0, acc);
        expect_ok(acc, 32'h00500093, 32'd0, 32'd5, 5'd1, 32'd5);

        // ADDI x2,x0,-1 then SUB x3,x1,x2 accepted three cycles later.
        issue(32'hFFF00113, 32'h4, acc_prev);
        expect_ok(acc_prev, 32'hFFF00113, 32'd0, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF);
        issue(32'h402081B3, 32'h8, acc);
        check("sub_accept_cycle", acc, acc_prev + 3);
        expect_ok(acc, 32'h402081B3, 32'd5, 32'hFFFFFFFF, 5'd3, 32'd6);

        // LUI x4,0x12345 ; AUIPC x5,0x1 at pc 0x100
        issue(32'h12345237, 32'hC, acc);
        expect_ok(acc, 32'h12345237, 32'h12345000, 32'd0, 5'd4, 32'h12345000);
        issue(32'h00001297, 32'h100, acc);
        expect_ok(acc, 32'h00001297, 32'h00001000, 32'h00000100, 5'd5, 32'h00001100);

        // ADDI x0,x0,7 retires but x0 stays zero.
        issue(32'h00700013, 32'h104, acc);
        expect_ok(acc, 32'h00700013, 32'd0, 32'd7, 5'd0, 32'd0);

        // LW x8,0(x1): rejected in the next cycle, nothing issued.
        issue(32'h0000A403, 32'h108, acc);
        resp_q.push_back('{is_done: 1'b0, cyc: acc + 1, chk_addr: 5'd8, chk_val: 32'd0});
        check("illegal_ready", {31'b0, bus.in_ready}, 32'd1);
        probe_q.push_back('{addr: 5'd3, val: 32'd6});
        probe_q.push_back('{addr: 5'd1, val: 32'd5});

        // ADDI x7,x0,3 refused by the ALU: illegal from WAIT, x7 unwritten.
        alu_reject = 1'b1;
        issue(32'h00300393, 32'h10C, acc);
        alu_q.push_back('{instr: 32'h00300393, op1: 32'd0, op2: 32'd3, cyc: acc + 1});
        resp_q.push_back('{is_done: 1'b0, cyc: acc + 3, chk_addr: 5'd7, chk_val: 32'd0});
        repeat (3) @(negedge clk);
        alu_reject = 1'b0;

        // ADDI x6,x0,9 with reset asserted during WAIT.
        issue(32'h00900313, 32'h110, acc);
        alu_q.push_back('{instr: 32'h00900313, op1: 32'd0, op2: 32'd9, cyc: acc + 1});
        @(negedge clk);                 // ISSUE
        @(negedge clk);                 // WAIT
        check("wait_ready_low", {31'b0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);                 // after reset edge
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_enable", {31'b0, bus.alu_enable}, 32'd0);
        check("midrst_op2", bus.alu_op2, 32'd0);
        check("midrst_ready", {31'b0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", {31'b0, bus.in_ready}, 32'd1);
        probe_q.push_back('{addr: 5'd6, val: 32'd0});
        probe_q.push_back('{addr: 5'd1, val: 32'd0});

        repeat (6) @(negedge clk);
        check("alu_q_drained", alu_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("probe_q_drained", probe_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
